// File: rtl/ddr_scrb_ctl.sv
// DDR scrubber: writes the range 0..MAX_ADDR with single-outstanding AXI4 INCR bursts.
// Optional build macro DDR_SCRB_PATTERN_EN: wdata carries the beat's byte address instead of zeros.
//
// state | meaning
// IDLE  | out of reset, waiting for scrb_start
// ADDR  | awvalid high, holding AW fields until awready
// DATA  | streaming the burst's W beats, wlast on the final one
// RESP  | bready high, waiting for the write response
// DONE  | pass finished, scrb_done held until the next start
module ddr_scrb_ctl #(
  parameter logic [63:0] MAX_ADDR         = 64'h3FFFFFFFF,
  parameter int unsigned BURST_LEN_MINUS1 = 15,
  parameter logic [15:0] AXI_ID           = 16'h0
) (
  input  logic         clk_main_a0,
  input  logic         rst_main_sync,
  input  logic         scrb_start,
  input  logic         scrb_stop,
  output logic         scrb_busy,
  output logic         scrb_done,
  output logic [63:0]  scrb_addr,
  output logic [15:0]  scrb_err_cnt,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  localparam logic [7:0]  LEN         = 8'(BURST_LEN_MINUS1);
  localparam logic [63:0] BURST_BYTES = 64'((BURST_LEN_MINUS1 + 1) * 64);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [15:0] err_q, err_d;
  logic [7:0]  beat_q, beat_d;
  logic [63:0] burst_last;
  logic        unused_bid;

  assign unused_bid = ^bid;
  assign burst_last = addr_q + BURST_BYTES - 64'd1;

  always_ff @(posedge clk_main_a0) begin
    if (rst_main_sync) begin
      state_q <= IDLE;
      addr_q  <= '0;
      err_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE, DONE: begin
        if (scrb_start) begin
          state_d = ADDR;
          addr_d  = '0;
          err_d   = '0;
          beat_d  = '0;
        end
      end
      ADDR: begin
        if (awready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (wready) begin
          if (beat_q == LEN) begin
            state_d = RESP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      RESP: begin
        if (bvalid) begin
          if (bresp != 2'b00 && err_q != 16'hFFFF) err_d = err_q + 16'd1;
          addr_d = addr_q + BURST_BYTES;
          // stop is only honoured here so an in-flight burst always completes
          if (burst_last >= MAX_ADDR || scrb_stop) state_d = DONE;
          else                                     state_d = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign scrb_busy    = (state_q == ADDR) || (state_q == DATA) || (state_q == RESP);
  assign scrb_done    = (state_q == DONE);
  assign scrb_addr    = addr_q;
  assign scrb_err_cnt = err_q;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = LEN;
  assign awsize  = 3'b110;
  assign awburst = 2'b01;
  assign awvalid = (state_q == ADDR);

  assign wvalid = (state_q == DATA);
  assign wlast  = (state_q == DATA) && (beat_q == LEN);
  assign wstrb  = '1;
  assign bready = (state_q == RESP);

`ifdef DDR_SCRB_PATTERN_EN
  logic [63:0] beat_addr;
  assign beat_addr = addr_q + {50'd0, beat_q, 6'd0};
  assign wdata     = {8{beat_addr}};
`else
  assign wdata = '0;
`endif

endmodule
